// File: rtl/psum_ofifo_pkg.sv
// -----------------------------------------------------------------------------
// psum_ofifo_pkg
//   Shared defaults and helpers for the partial-sum output FIFO.
//   Contents:
//     BW_PSUM, COL, DEPTH : default lane width, lane count, entries per lane
//     ptr_w(d)            : pointer width for a depth-d lane, log2(d)+1. The
//                           extra MSB tells full from empty when the address
//                           bits of the two pointers are equal.
// -----------------------------------------------------------------------------
package psum_ofifo_pkg;

    localparam int BW_PSUM = 32;
    localparam int COL     = 8;
    localparam int DEPTH   = 16;

    function automatic int ptr_w(input int d);
        return $clog2(d) + 1;
    endfunction

endpackage

// File: rtl/psum_fifo_lane.sv
// -----------------------------------------------------------------------------
// psum_fifo_lane
//   One independent lane of the partial-sum output FIFO. Data is stored as
//   given, with no arithmetic applied. The head entry is always presented on
//   out (first-word-fall-through). Masking the head while the FIFO is empty is
//   left to the parent.
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous, active-high; zeroes both pointers
//     wr    : push strobe, ignored while the lane is full
//     rd    : pop strobe, ignored while the lane is empty
//     in    : write data
//     out   : raw head entry; meaningless while empty is high
//     empty : lane holds no entries
//     full  : lane holds depth entries
// -----------------------------------------------------------------------------
module psum_fifo_lane
    import psum_ofifo_pkg::*;
#(
    parameter int bw_psum = BW_PSUM,
    parameter int depth   = DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic               rd,
    input  logic [bw_psum-1:0] in,
    output logic [bw_psum-1:0] out,
    output logic               empty,
    output logic               full
);

    localparam int PW = ptr_w(depth);
    localparam int AW = PW - 1;

    logic [PW-1:0]      r_wptr;
    logic [PW-1:0]      r_rptr;
    logic [bw_psum-1:0] r_mem [depth];

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    // Both flags come from the pointer registers alone.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PW-1] != r_rptr[PW-1]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    // Full is judged on the state before the edge, so a write to a full lane
    // is dropped even when the same edge pops.
    assign w_push = wr & ~w_full;
    assign w_pop  = rd & ~w_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // The storage array has no reset. Because the pointers are cleared, any
    // stale contents can never be read back.
    always_ff @(posedge clk) begin
        if (w_push && !reset) r_mem[r_wptr[AW-1:0]] <= in;
    end

    assign out   = r_mem[r_rptr[AW-1:0]];
    assign empty = w_empty;
    assign full  = w_full;

endmodule

// File: rtl/psum_ofifo.sv
// -----------------------------------------------------------------------------
// psum_ofifo
//   Collects partial sums from col mac_col lanes into per-lane FIFOs. Rows are
//   popped together once every lane holds at least one entry. Lanes fill
//   independently, so writes may arrive skewed by any number of cycles. Rows
//   pair entries by arrival order within each lane.
//   Optional macro: PSUM_OFIFO_OVF_EN adds a sticky per-lane overflow output.
//   Ports:
//     clk     : rising-edge clock
//     reset   : asynchronous, active-high
//     in      : lane i psum at [i*bw_psum +: bw_psum]
//     wr      : per-lane write strobe
//     rd      : pop one row from all lanes; ignored unless o_valid
//     out     : head row, FWFT; all zeros while o_valid is low
//     o_valid : every lane non-empty
//     o_full  : any lane full
//     o_ready : ~o_full
//     ovf     : (PSUM_OFIFO_OVF_EN only) sticky per-lane dropped-write flag
// -----------------------------------------------------------------------------
module psum_ofifo
    import psum_ofifo_pkg::*;
#(
    parameter int col     = COL,
    parameter int bw_psum = BW_PSUM,
    parameter int depth   = DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col*bw_psum-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [col*bw_psum-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
`ifdef PSUM_OFIFO_OVF_EN
    output logic                   o_ready,
    output logic [col-1:0]         ovf
`else
    output logic                   o_ready
`endif
);

    logic [col*bw_psum-1:0] w_head;
    logic [col-1:0]         w_empty;
    logic [col-1:0]         w_full;
    logic                   w_pop;

    // A row pops from every lane at once, and only when every lane has an
    // entry. This keeps the lanes aligned by arrival order.
    assign w_pop = rd & o_valid;

    genvar g;
    generate
        for (g = 0; g < col; g++) begin : g_lane
            psum_fifo_lane #(
                .bw_psum (bw_psum),
                .depth   (depth)
            ) u_lane (
                .clk   (clk),
                .reset (reset),
                .wr    (wr[g]),
                .rd    (w_pop),
                .in    (in[g*bw_psum +: bw_psum]),
                .out   (w_head[g*bw_psum +: bw_psum]),
                .empty (w_empty[g]),
                .full  (w_full[g])
            );
        end
    endgenerate

    assign o_valid = ~|w_empty;
    assign o_full  = |w_full;
    assign o_ready = ~o_full;
    assign out     = o_valid ? w_head : '0;

`ifdef PSUM_OFIFO_OVF_EN
    logic [col-1:0] r_ovf;

    // The lane drops a write whenever wr meets full on the pre-edge state.
    // This flag records that drop and holds it until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_ovf <= '0;
        else       r_ovf <= r_ovf | (wr & w_full);
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_psum_ofifo.sv
module tb_psum_ofifo;
    import psum_ofifo_pkg::*;

    localparam int C = COL;
    localparam int B = BW_PSUM;
    localparam int D = DEPTH;
    localparam int W = C * B;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] tb_in = '0;
    logic [C-1:0] tb_wr = '0;
    logic         tb_rd = 1'b0;
    logic [W-1:0] tb_out;
    logic         tb_valid, tb_full, tb_ready;
`ifdef PSUM_OFIFO_OVF_EN
    logic [C-1:0] tb_ovf;
`endif

    psum_ofifo dut (
        .clk     (clk),
        .reset   (reset),
        .in      (tb_in),
        .wr      (tb_wr),
        .rd      (tb_rd),
        .out     (tb_out),
        .o_valid (tb_valid),
        .o_full  (tb_full),
`ifdef PSUM_OFIFO_OVF_EN
        .o_ready (tb_ready),
        .ovf     (tb_ovf)
`else
        .o_ready (tb_ready)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one queue per lane plus sticky overflow flags.
    logic [B-1:0] q [C][$];
    logic [C-1:0] m_ovf = '0;

    function automatic bit m_valid();
        for (int i = 0; i < C; i++) if (q[i].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_full();
        for (int i = 0; i < C; i++) if (q[i].size() == D) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [W-1:0] m_out();
        logic [W-1:0] r = '0;
        if (m_valid())
            for (int i = 0; i < C; i++) r[i*B +: B] = q[i][0];
        return r;
    endfunction

    function automatic logic [W-1:0] rand_row();
        logic [W-1:0] r;
        for (int i = 0; i < C; i++) r[i*B +: B] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < C; i++) q[i].delete();
        m_ovf = '0;
    endtask

    task automatic model_edge(input logic [C-1:0] w, input logic [W-1:0] d, input logic r);
        bit           v;
        logic [C-1:0] f;
        v = m_valid();
        for (int i = 0; i < C; i++) f[i] = (q[i].size() == D);
        if (r && v)
            for (int i = 0; i < C; i++) void'(q[i].pop_front());
        for (int i = 0; i < C; i++)
            if (w[i]) begin
                if (!f[i]) q[i].push_back(d[i*B +: B]);
                else       m_ovf[i] = 1'b1;
            end
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_valid"}, W'(tb_valid), W'(m_valid()));
        chk({tag, "_full"},  W'(tb_full),  W'(m_full()));
        chk({tag, "_ready"}, W'(tb_ready), W'(!m_full()));
        chk({tag, "_out"},   tb_out,       m_out());
`ifdef PSUM_OFIFO_OVF_EN
        chk({tag, "_ovf"},   W'(tb_ovf),   W'(m_ovf));
`endif
    endtask

    // Drive inputs after an edge, apply them at the next edge, then check the outputs 1ns later.
    task automatic step(input logic [C-1:0] w, input logic [W-1:0] d, input logic r, input string tag);
        tb_wr = w;
        tb_in = d;
        tb_rd = r;
        @(posedge clk);
        model_edge(w, d, r);
        #1;
        tb_wr = '0;
        tb_rd = 1'b0;
        tb_in = '0;
        chk_all(tag);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        chk_all("rst_pulse");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [W-1:0] row, row2, dead;
        logic [B-1:0] a, b;

        // Reset assertion before any clock edge.
        #2 reset = 1'b1;
        #1 chk_all("reset");
        chk("reset_out_zero", tb_out, '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Write one row with lane i = i+1, idle, then pop.
        for (int i = 0; i < C; i++) row[i*B +: B] = B'(i + 1);
        step('1, row, 1'b0, "t1_wr");
        step('0, '0, 1'b0, "t1_idle");
        chk("t1_row", tb_out, row);
        chk("t1_valid", W'(tb_valid), W'(1));
        step('0, '0, 1'b1, "t1_pop");
        chk("t1_out_zero", tb_out, '0);

        // Skewed lane writes: lane 7 arrives last, at cycle 3.
        row  = rand_row();
        row2 = rand_row();
        a = row[0 +: B];
        b = row2[7*B +: B];
        step(8'h01, row, 1'b0, "t2_c0");
        chk("t2_c0_valid", W'(tb_valid), W'(0));
        step(8'h7E, row, 1'b0, "t2_c1");
        step('0, '0, 1'b0, "t2_c2");
        chk("t2_c2_valid", W'(tb_valid), W'(0));
        step(8'h80, row2, 1'b0, "t2_c3");
        chk("t2_c3_valid", W'(tb_valid), W'(1));
        chk("t2_lane0", W'(tb_out[0 +: B]), W'(a));
        chk("t2_lane7", W'(tb_out[7*B +: B]), W'(b));
        step('0, '0, 1'b1, "t2_pop");

        // Fill to full, drop writes (also on a popping edge), then drain in order.
        for (int i = 0; i < D; i++) step('1, rand_row(), 1'b0, "t3_fill");
        chk("t3_full", W'(tb_full), W'(1));
        chk("t3_ready", W'(tb_ready), W'(0));
        for (int i = 0; i < C; i++) dead[i*B +: B] = 32'hDEAD;
        step('1, dead, 1'b0, "t3_drop");
        step('1, dead, 1'b1, "t3_drop_pop");
`ifdef PSUM_OFIFO_OVF_EN
        chk("t3_ovf", W'(tb_ovf), W'(8'hFF));
`endif
        for (int i = 0; i < D - 1; i++) begin
            chk("t3_no_dead", W'(tb_out[0 +: B] == 32'hDEAD), W'(0));
            step('0, '0, 1'b1, "t3_drain");
        end
        chk("t3_empty", W'(tb_valid), W'(0));

        // 15 rows held, then 40 cycles of simultaneous write and pop across pointer wrap.
        for (int i = 0; i < D - 1; i++) step('1, rand_row(), 1'b0, "t4_fill");
        for (int i = 0; i < 40; i++) step('1, rand_row(), 1'b1, "t4_wrap");
        chk("t4_not_full", W'(tb_full), W'(0));
        for (int i = 0; i < D - 1; i++) step('0, '0, 1'b1, "t4_drain");
        chk("t4_empty", W'(tb_valid), W'(0));

        // Random skewed traffic with the full-lane drops it produces.
        for (int i = 0; i < 300; i++)
            step(C'($urandom), rand_row(), ($urandom_range(0, 2) == 0), "t5_rand");
        for (int i = 0; i < 20; i++) step('0, '0, 1'b1, "t5_drain");

        // Pop on empty lanes, then an asynchronous reset in the middle of a burst.
        pulse_reset();
        step('0, '0, 1'b1, "t6_rd_empty");
        for (int i = 0; i < 5; i++) step('1, rand_row(), 1'b0, "t6_fill");
        step('1, rand_row(), 1'b1, "t6_burst");
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk_all("t6_async_rst");
        chk("t6_valid0", W'(tb_valid), W'(0));
        chk("t6_out0", tb_out, '0);
        @(negedge clk);
        reset = 1'b0;
        step('1, row, 1'b0, "t6_after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/psum_ofifo.md
PSUM_OFIFO -- requirements
Module: psum_ofifo

Interface
REQ-001 SHALL have parameter col, default 8: number of mac_col lanes collected.
REQ-002 SHALL have parameter bw_psum, default 32: partial-sum width per lane.
REQ-003 SHALL have parameter depth, default 16: entries per lane; power of 2, at least 2.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port in, input, col*bw_psum: lane i psum at bits [i*bw_psum +: bw_psum].
REQ-007 SHALL have port wr, input, col: per-lane write strobe (mac_col fifo_wr).
REQ-008 SHALL have port rd, input, 1: pop one row from all lanes.
REQ-009 SHALL have port out, output, col*bw_psum: head row, lane i at [i*bw_psum +: bw_psum].
REQ-010 SHALL have port o_valid, output, 1: every lane non-empty.
REQ-011 SHALL have port o_full, output, 1: any lane full.
REQ-012 SHALL have port o_ready, output, 1: equals ~o_full.

Function
REQ-013 SHALL store in lane i at a rising edge when wr[i]=1 and lane i is not full, judged on pre-edge state.
REQ-014 SHALL drop the write, without changing state, when wr[i]=1 and lane i is full, even if the same edge pops; there is no full-bypass.
REQ-015 SHALL pop the head of every lane at a rising edge when rd=1 and o_valid=1.
REQ-016 SHALL ignore rd when o_valid=0, with no pointer change.
REQ-017 SHALL, on a simultaneous valid write and pop in a non-full lane, do both; that lane's count is unchanged.
REQ-018 SHALL drive out first-word-fall-through: out shows the lane heads combinationally while o_valid=1.
REQ-019 SHALL drive out to all zeros while o_valid=0.
REQ-020 SHALL use per-lane read and write pointers of log2(depth)+1 bits that wrap modulo 2*depth; empty when the pointers are equal; full when the MSBs differ and the remaining bits are equal.
REQ-021 SHALL derive o_valid, o_full and o_ready combinationally from pointer registers only, never from in, wr or rd.
REQ-022 SHALL keep lanes independent: writes may arrive skewed by any number of cycles; rows pair by arrival order per lane.
REQ-023 SHALL store data unmodified, with no arithmetic and no sign handling.

Reset
REQ-024 SHALL, on reset assertion, immediately zero all pointers, giving o_valid=0, o_full=0, o_ready=1 and out=0; mid-operation contents are discarded.
REQ-025 SHALL ignore wr and rd while reset=1; storage arrays need not be reset.

Configuration
REQ-026 SHALL, with macro PSUM_OFIFO_OVF_EN defined, add port ovf, output, col bits: ovf[i] is sticky, set the cycle after a dropped write on lane i, and cleared only by reset.
REQ-027 SHALL, without PSUM_OFIFO_OVF_EN, have no ovf port and no overflow logic; all other behaviour is identical.

Structure
REQ-028 SHALL take default widths (BW_PSUM=32, COL=8, DEPTH=16) and the pointer-width function from shared package psum_ofifo_pkg.
REQ-029 SHALL implement one lane as sub-module psum_fifo_lane (clk, reset, wr, rd, in, out, empty, full), instantiated col times by generate.

Verification
REQ-030 SHALL cover this bench case: after reset, pulse wr=8'hFF once with lane i data = i+1, then one idle cycle -> o_valid=1 and out lanes equal 1..8; rd=1 for one cycle -> o_valid=0 and out=0.
REQ-031 SHALL cover this bench case: wr[0] at cycle 0, wr[7] at cycle 3 (skew) -> o_valid stays 0 until the edge after the cycle-3 write, then the row pairs both values.
REQ-032 SHALL cover this bench case: 16 writes on all lanes with no reads -> o_full=1, o_ready=0; a 17th write with value 32'hDEAD is dropped; drain 16 rows, all in write order, with no DEAD value; with PSUM_OFIFO_OVF_EN, ovf=8'hFF.
REQ-033 SHALL cover this bench case: with 15 rows held, simultaneous wr=8'hFF and rd=1 for 40 cycles -> count stays 15 and order is preserved across pointer wrap.
REQ-034 SHALL cover this bench case: rd=1 with all lanes empty -> no change; then assert reset asynchronously mid-burst with 5 rows held -> o_valid=0 and out=0 before the next clock edge.
